vw_bulk_loader: RTL and testbench
=================================

// Module: vw_bulk_loader
// PURPOSE
//  Wishbone slave that loads Virtual Wire (AltSourceProbe) bulk packets into a byte FIFO for the CPU.
//  Generalises the single-buffer bulk port: parametrised packet width, strobe count and FIFO depth.
//  Adds an overrun flag, a status register and optional two-byte word pops.
//  Sits on the I/O Wishbone bus in place of the flash port; the console loader drives the vw_* side.
// PARAMETERS
//  BULK_W      256  bulk packet width in bits; multiple of 8, >=32
//  NSTROBE     2    toggle strobes at vw_bulkdata_in[BULK_W-1 -: NSTROBE]; 1..4
//  CNT_W       5    payload byte-count field width, at vw_bulkdata_in[BULK_W-8 +: CNT_W]
//  FIFO_AW     5    FIFO address width; depth = 2**FIFO_AW bytes
//  WORD_POP    1    1: a read of DATA with wb_sel_i==2'b11 pops two bytes, {b1,b0}
// PORTS
//  wb_clk_i         in   1        system clock
//  wb_rst_n_i       in   1        asynchronous reset, active low
//  wb_dat_i         in   16       write data
//  wb_dat_o         out  16       read data, registered
//  wb_adr_i         in   2        0=ALO 1=AHI 2=DATA 3=STATUS
//  wb_we_i          in   1        write enable
//  wb_sel_i         in   2        byte lanes
//  wb_stb_i         in   1        strobe
//  wb_cyc_i         in   1        cycle
//  wb_ack_o         out  1        acknowledge, registered
//  vw_bulkdata_in   in   BULK_W   probe packet: strobes | count | payload bytes [BULK_W-9:0], byte0 at LSB
//  vw_bulkaddr_out  out  32       source address, {AHI,ALO}
// BEHAVIOUR
//  Reset (async, wb_rst_n_i=0): wb_dat_o=0, wb_ack_o=0, address=0, FIFO empty, overrun=0,
//   unpacker IDLE, strobe sync regs=0.
//  Bus: op=stb&cyc. wb_ack_o rises the cycle after op and holds high for exactly one cycle.
//   The cycle after that it is low even if op persists. Register side effects occur on the ack cycle only.
//  ALO/AHI write: address[15:0] / address[31:16] <= wb_dat_i. Reads of ALO/AHI return the value.
//  DATA read: returns {level[7:0], byte} and pops 1 byte. A word pop (WORD_POP=1, sel=11, level>=2)
//   returns {b1,b0} and pops 2. An empty FIFO returns 16'h0000 with no pop. With sel=11 and
//   level==1, returns a single byte, popping 1. DATA write is ignored.
//  STATUS read: [0]=empty [1]=full [2]=overrun [3]=busy, [15:8]=level (zero-extended, saturating at 255).
//   STATUS write: wb_dat_i[2]=1 clears overrun (W1C).
//  Strobes: each bit passes through a 2-FF synchroniser; a rising edge of any synchronised strobe is an
//   event. The packet is sampled from vw_bulkdata_in on the event cycle, and is stable by protocol.
//  Unpacker FSM:
//   IDLE   : on event, latch payload + count (count clamped to (BULK_W-8)/8); ->UNPACK if count!=0.
//   UNPACK : each cycle with FIFO not full, push shreg[7:0], shift right 8, count-1; ->IDLE when count hits 0.
//            FIFO full: stall, holding state.
//  An event while in UNPACK, or coincident strobe edges beyond the first: packet dropped, overrun<=1.
//  Push and pop in the same cycle: level unchanged, both take effect. Pointers wrap modulo 2**FIFO_AW.
//  Level is FIFO_AW+1 bits wide.
//  Overrun set and clear in the same cycle: set wins.
//  Reset mid-UNPACK: the partial packet is discarded; the next strobe edge after reset starts fresh.
// STRUCTURE
//  Package vw_bulk_pkg: register offsets (ALO/AHI/DATA/STATUS), STATUS bit indices,
//   unpacker state encoding (IDLE, UNPACK).
//  Sub-module vw_byte_fifo: sync FIFO, 8-bit wide, 2**FIFO_AW deep, push/pop/level/full/empty.
//   Same clock and reset; supports 1- or 2-byte pop, with the second byte read via rd_ptr+1.
//  Top holds the bus decode, synchronisers, unpacker FSM and address register.
// TESTING
//  Write ALO=0x1234, AHI=0xABCD -> vw_bulkaddr_out=0xABCD1234; each ack is a 1-cycle pulse.
//  Strobe A edge, count=3, bytes 11,22,33 -> STATUS level=3; 3 byte reads -> 0x0311, 0x0222, 0x0133.
//   A 4th read -> 0x0000, empty=1.
//  Alternate strobes A/B with 2 packets of count=31 and FIFO_AW=5: second packet stalls while full.
//   Draining yields all 62 bytes in order; overrun=0.
//  Strobe edge during UNPACK -> packet dropped, overrun=1; STATUS write 0x0004 -> overrun=0.
//  Word read sel=11 with bytes 0xAA,0xBB -> 0xBBAA, level-=2. Then level==1: word read -> {level,byte}.
//  Assert wb_rst_n_i mid-UNPACK -> immediately level=0, busy=0, wb_ack_o=0, address=0.

Source files
------------

// File: rtl/vw_bulk_pkg.sv
// vw_bulk_pkg: register offsets, STATUS bit indices and unpacker states for vw_bulk_loader
package vw_bulk_pkg;
    localparam logic [1:0] A_ALO  = 2'd0;
    localparam logic [1:0] A_AHI  = 2'd1;
    localparam logic [1:0] A_DATA = 2'd2;
    localparam logic [1:0] A_STAT = 2'd3;
    localparam int B_EMPTY = 0;
    localparam int B_FULL  = 1;
    localparam int B_OVR   = 2;
    localparam int B_BUSY  = 3;
    localparam logic S_IDLE   = 1'b0;
    localparam logic S_UNPACK = 1'b1;
endpackage

// File: rtl/vw_byte_fifo.sv
// vw_byte_fifo: 8-bit sync FIFO, 2**AW deep, one push and a 1- or 2-byte pop per cycle
//   i_clk, i_rst_n   clock, async active-low reset
//   i_push, i_din    write one byte (caller guarantees not full)
//   i_pop1, i_pop2   pop one / two bytes (caller guarantees enough level)
//   o_d0, o_d1       bytes at rd_ptr and rd_ptr+1
//   o_level          fill level, AW+1 bits
//   o_full, o_empty  status
module vw_byte_fifo #(
    parameter int AW = 5
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic [7:0]    i_din,
    input  logic          i_pop1,
    input  logic          i_pop2,
    output logic [7:0]    o_d0,
    output logic [7:0]    o_d1,
    output logic [AW:0]   o_level,
    output logic          o_full,
    output logic          o_empty
);
    logic [7:0]    r_mem [2**AW];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_level;
    logic [AW-1:0] w_rp1;
    logic [1:0]    w_popn;
    assign w_rp1   = r_rp + 1'b1;
    assign w_popn  = {i_pop2, i_pop1 & ~i_pop2};
    assign o_d0    = r_mem[r_rp];
    assign o_d1    = r_mem[w_rp1];
    assign o_level = r_level;
    assign o_full  = r_level[AW];
    assign o_empty = r_level == '0;
    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wp] <= i_din;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
        end else begin
            r_wp    <= r_wp + AW'(i_push);
            r_rp    <= r_rp + AW'(w_popn);
            r_level <= r_level + (AW+1)'(i_push) - (AW+1)'(w_popn);
        end
    end
endmodule

// File: rtl/vw_bulk_loader.sv
// vw_bulk_loader: Wishbone slave unpacking Virtual Wire bulk packets into a byte FIFO
//   wb_clk_i, wb_rst_n_i   clock, async active-low reset
//   wb_*                   16-bit Wishbone slave: 0=ALO 1=AHI 2=DATA 3=STATUS, registered ack/data
//   vw_bulkdata_in         probe packet: toggle strobes | byte count | payload, byte0 at LSB
//   vw_bulkaddr_out        source address {AHI,ALO}
module vw_bulk_loader
    import vw_bulk_pkg::*;
#(
    parameter int BULK_W   = 256,
    parameter int NSTROBE  = 2,
    parameter int CNT_W    = 5,
    parameter int FIFO_AW  = 5,
    parameter int WORD_POP = 1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n_i,
    input  logic [15:0]       wb_dat_i,
    output logic [15:0]       wb_dat_o,
    input  logic [1:0]        wb_adr_i,
    input  logic              wb_we_i,
    input  logic [1:0]        wb_sel_i,
    input  logic              wb_stb_i,
    input  logic              wb_cyc_i,
    output logic              wb_ack_o,
    input  logic [BULK_W-1:0] vw_bulkdata_in,
    output logic [31:0]       vw_bulkaddr_out
);
    localparam int PW   = BULK_W - 8;
    localparam int MAXB = PW / 8;

    logic               r_ack;
    logic [15:0]        r_dat;
    logic [31:0]        r_addr;
    logic [NSTROBE-1:0] r_s1, r_s2, r_s3;
    logic               r_state;
    logic [PW-1:0]      r_sh;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovr;

    logic               w_acc, w_dread, w_word, w_pop1, w_pop2, w_push;
    logic               w_full, w_empty, w_evt, w_multi, w_set, w_clr;
    logic [NSTROBE-1:0] w_rise;
    logic [CNT_W-1:0]   w_fld, w_cnt_in;
    logic [7:0]         w_b0, w_b1, w_lsat;
    logic [FIFO_AW:0]   w_level;
    logic [15:0]        w_lvl16, w_stat, w_ddat, w_rdata;
    logic               w_unused;

    assign w_unused = ^vw_bulkdata_in;

    // The access phase is the cycle before ack; the ack-low cycle that follows blocks back-to-back repeats.
    assign w_acc   = wb_stb_i & wb_cyc_i & ~r_ack;
    assign w_dread = w_acc & ~wb_we_i & (wb_adr_i == A_DATA) & ~w_empty;
    assign w_word  = (WORD_POP != 0) && (wb_sel_i == 2'b11) && (w_lvl16 >= 16'd2);
    assign w_pop1  = w_dread & ~w_word;
    assign w_pop2  = w_dread & w_word;
    assign w_clr   = w_acc & wb_we_i & (wb_adr_i == A_STAT) & wb_dat_i[B_OVR];

    assign w_rise   = r_s2 & ~r_s3;
    assign w_evt    = |w_rise;
    assign w_multi  = (w_rise & (w_rise - 1'b1)) != '0;
    assign w_set    = w_evt & ((r_state == S_UNPACK) | w_multi);
    assign w_fld    = vw_bulkdata_in[BULK_W-8 +: CNT_W];
    assign w_cnt_in = (32'(w_fld) > MAXB) ? CNT_W'(MAXB) : w_fld;
    assign w_push   = (r_state == S_UNPACK) & ~w_full;

    assign w_lvl16 = 16'(w_level);
    assign w_lsat  = (|w_lvl16[15:8]) ? 8'hFF : w_lvl16[7:0];

    always_comb begin
        w_stat          = '0;
        w_stat[B_EMPTY] = w_empty;
        w_stat[B_FULL]  = w_full;
        w_stat[B_OVR]   = r_ovr;
        w_stat[B_BUSY]  = r_state == S_UNPACK;
        w_stat[15:8]    = w_lsat;
        w_ddat  = w_empty ? 16'h0000 : w_word ? {w_b1, w_b0} : {w_lvl16[7:0], w_b0};
        w_rdata = (wb_adr_i == A_ALO)  ? r_addr[15:0]  :
                  (wb_adr_i == A_AHI)  ? r_addr[31:16] :
                  (wb_adr_i == A_DATA) ? w_ddat : w_stat;
    end

    vw_byte_fifo #(.AW(FIFO_AW)) u_fifo (
        .i_clk   (wb_clk_i),
        .i_rst_n (wb_rst_n_i),
        .i_push  (w_push),
        .i_din   (r_sh[7:0]),
        .i_pop1  (w_pop1),
        .i_pop2  (w_pop2),
        .o_d0    (w_b0),
        .o_d1    (w_b1),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_ack  <= 1'b0;
            r_dat  <= '0;
            r_addr <= '0;
            r_ovr  <= 1'b0;
        end else begin
            r_ack <= w_acc;
            if (w_acc) r_dat <= w_rdata;
            if (w_acc & wb_we_i & (wb_adr_i == A_ALO)) r_addr[15:0] <= wb_dat_i;
            if (w_acc & wb_we_i & (wb_adr_i == A_AHI)) r_addr[31:16] <= wb_dat_i;
            r_ovr <= w_set ? 1'b1 : w_clr ? 1'b0 : r_ovr;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_s1    <= '0;
            r_s2    <= '0;
            r_s3    <= '0;
            r_state <= S_IDLE;
            r_sh    <= '0;
            r_cnt   <= '0;
        end else begin
            r_s1 <= vw_bulkdata_in[BULK_W-1 -: NSTROBE];
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            if (r_state == S_IDLE) begin
                if (w_evt) begin
                    r_sh    <= vw_bulkdata_in[PW-1:0];
                    r_cnt   <= w_cnt_in;
                    r_state <= (w_cnt_in != '0) ? S_UNPACK : S_IDLE;
                end
            end else if (w_push) begin
                r_sh  <= r_sh >> 8;
                r_cnt <= r_cnt - 1'b1;
                if (r_cnt == CNT_W'(1)) r_state <= S_IDLE;
            end
        end
    end

    assign wb_ack_o        = r_ack;
    assign wb_dat_o        = r_dat;
    assign vw_bulkaddr_out = r_addr;
endmodule

// File: tb/tb_vw_bulk_loader.sv
// tb_vw_bulk_loader: directed scoreboard bench for vw_bulk_loader at default parameters
module tb_vw_bulk_loader;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [15:0]  dat_i = '0;
    logic [15:0]  dat_o;
    logic [1:0]   adr = '0;
    logic [1:0]   sel = '0;
    logic         we = 1'b0, stb = 1'b0, cyc = 1'b0;
    logic         ack;
    logic [255:0] vw = '0;
    logic [31:0]  addr;
    int           passed = 0, total = 0, fails = 0;
    logic [7:0]   sb [$];
    logic [15:0]  rd;

    always #5 clk = ~clk;

    vw_bulk_loader dut (
        .wb_clk_i        (clk),
        .wb_rst_n_i      (rst_n),
        .wb_dat_i        (dat_i),
        .wb_dat_o        (dat_o),
        .wb_adr_i        (adr),
        .wb_we_i         (we),
        .wb_sel_i        (sel),
        .wb_stb_i        (stb),
        .wb_cyc_i        (cyc),
        .wb_ack_o        (ack),
        .vw_bulkdata_in  (vw),
        .vw_bulkaddr_out (addr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] st(input int lvl, input bit ovr, input bit busy);
        return {8'(lvl), 4'h0, busy, ovr, lvl == 32, lvl == 0};
    endfunction

    task automatic bus(input logic [1:0] a, input logic w, input logic [1:0] s,
                       input logic [15:0] d, input bit hold, output logic [15:0] r);
        int n;
        @(posedge clk); #1;
        adr = a; we = w; sel = s; dat_i = d; stb = 1'b1; cyc = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!ack && n < 8);
        check("ack", 32'(ack), 32'd1);
        r = dat_o;
        if (hold) begin
            @(posedge clk); #1;
            check("ack_pulse", 32'(ack), 32'd0);
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic status(input string tag, input logic [15:0] exp);
        logic [15:0] r;
        bus(2'd3, 1'b0, 2'b11, 16'h0, 1'b0, r);
        check(tag, 32'(r), 32'(exp));
    endtask

    // FIFO holds at most 32 of the pending bytes; the rest wait in the unpacker.
    task automatic rd_data(input logic [1:0] s, input string tag);
        logic [15:0] e, r;
        logic [7:0]  b0, b1;
        int lvl;
        lvl = sb.size() > 32 ? 32 : sb.size();
        if (lvl == 0) e = 16'h0;
        else if (s == 2'b11 && lvl >= 2) begin
            b0 = sb.pop_front();
            b1 = sb.pop_front();
            e = {b1, b0};
        end else e = {8'(lvl), sb.pop_front()};
        bus(2'd2, 1'b0, s, 16'h0, 1'b0, r);
        check(tag, 32'(r), 32'(e));
    endtask

    task automatic pkt(input int s, input int cnt, input logic [7:0] base,
                       input logic [7:0] step, input bit keep);
        @(posedge clk); #1;
        vw = '0;
        for (int i = 0; i < 31; i++) vw[i*8 +: 8] = base + 8'(i) * step;
        vw[252:248] = 5'(cnt);
        vw[254+s] = 1'b1;
        if (keep) for (int i = 0; i < cnt; i++) sb.push_back(base + 8'(i) * step);
        repeat (5) @(posedge clk);
        #1 vw[254+s] = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #3;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_dat", 32'(dat_o), 32'd0);
        check("rst_addr", addr, 32'd0);
        #9 rst_n = 1'b1;
        status("rst_status", st(0, 0, 0));

        bus(2'd0, 1'b1, 2'b11, 16'h1234, 1'b1, rd);
        bus(2'd1, 1'b1, 2'b11, 16'hABCD, 1'b0, rd);
        check("addr_out", addr, 32'hABCD1234);
        bus(2'd0, 1'b0, 2'b11, 16'h0, 1'b0, rd);
        check("alo_rd", 32'(rd), 32'h1234);
        bus(2'd1, 1'b0, 2'b11, 16'h0, 1'b0, rd);
        check("ahi_rd", 32'(rd), 32'hABCD);

        pkt(0, 3, 8'h11, 8'h11, 1'b1);
        repeat (8) @(posedge clk);
        status("lvl3", st(3, 0, 0));
        for (int i = 0; i < 4; i++) rd_data(2'b01, "byte_rd");
        status("empty", st(0, 0, 0));

        pkt(0, 31, 8'h01, 8'h01, 1'b1);
        repeat (40) @(posedge clk);
        pkt(1, 31, 8'h80, 8'h01, 1'b1);
        repeat (40) @(posedge clk);
        status("full_stall", st(32, 0, 1));
        for (int i = 0; i < 62; i++) rd_data(2'b01, "drain62");
        status("drained", st(0, 0, 0));

        pkt(0, 31, 8'h40, 8'h03, 1'b1);
        pkt(1, 5, 8'hE0, 8'h01, 1'b0);
        repeat (40) @(posedge clk);
        status("overrun", st(31, 1, 0));
        bus(2'd3, 1'b1, 2'b11, 16'h0004, 1'b0, rd);
        status("ovr_clr", st(31, 0, 0));
        for (int i = 0; i < 31; i++) rd_data(2'b01, "drain31");

        pkt(0, 3, 8'hAA, 8'h11, 1'b1);
        repeat (10) @(posedge clk);
        rd_data(2'b11, "word_pop");
        status("lvl1", st(1, 0, 0));
        rd_data(2'b11, "word_lvl1");
        status("empty2", st(0, 0, 0));

        pkt(0, 31, 8'h10, 8'h01, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_ack", 32'(ack), 32'd0);
        check("mrst_addr", addr, 32'd0);
        check("mrst_dat", 32'(dat_o), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        status("mrst_status", st(0, 0, 0));
        pkt(1, 2, 8'h55, 8'h11, 1'b1);
        repeat (8) @(posedge clk);
        rd_data(2'b01, "fresh0");
        rd_data(2'b01, "fresh1");
        status("fresh_empty", st(0, 0, 0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
